// File: rtl/shift_reg_en.sv
// rtl/shift_reg_en.sv - WIDTH-bit operand register with load/clear/shift/rotate/inc/dec and busy/done handshake
// Optional feature macro: SHIFT_REG_ARITH_SHR_EN (SHR fills with the sign bit instead of in_SIN)

module shift_reg_en #(
  parameter int                 WIDTH     = 8,
  parameter int                 AMT_W     = 3,
  parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
  input  logic               in_CLK,
  input  logic               in_RST_N,
  input  logic               in_EN,
  input  logic [2:0]         in_CMD,
  input  logic [WIDTH-1:0]   in_D,
  input  logic [AMT_W-1:0]   in_AMT,
  input  logic               in_SIN,
  output logic [WIDTH-1:0]   data_out,
  output logic               out_BUSY,
  output logic               out_DONE,
  output logic               out_SOUT,
  output logic               out_CARRY,
  output logic               out_ZERO
);

  typedef enum logic [2:0] {
    CMD_HOLD  = 3'b000,
    CMD_LOAD  = 3'b001,
    CMD_CLEAR = 3'b010,
    CMD_SHL   = 3'b011,
    CMD_SHR   = 3'b100,
    CMD_ROL   = 3'b101,
    CMD_INC   = 3'b110,
    CMD_DEC   = 3'b111
  } cmd_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

  localparam logic [WIDTH-1:0] ONE_W   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [AMT_W-1:0] ONE_AMT = {{(AMT_W-1){1'b0}}, 1'b1};

  state_e             state_q, state_d;
  cmd_e               cmd_q, cmd_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic [AMT_W-1:0]   cnt_q, cnt_d;
  logic               done_q, done_d;
  logic               sout_q, sout_d;
  logic               carry_q, carry_d;

  logic               shr_fill;
  cmd_e               cmd_in;

  assign cmd_in = cmd_e'(in_CMD);

  // SHR fill bit: sign bit for arithmetic shift, otherwise the serial input
`ifdef SHIFT_REG_ARITH_SHR_EN
  assign shr_fill = data_q[WIDTH-1];
`else
  assign shr_fill = in_SIN;
`endif

  // Next-state logic: command acceptance in IDLE, one-bit-per-cycle shifting in SHIFT
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    done_d  = 1'b0;
    sout_d  = sout_q;
    carry_d = carry_q;

    case (state_q)
      ST_IDLE: begin
        if (in_EN) begin
          case (cmd_in)
            CMD_HOLD: begin
              // nothing changes and no completion pulse
            end
            CMD_LOAD: begin
              data_d  = in_D;
              carry_d = 1'b0;
              done_d  = 1'b1;
            end
            CMD_CLEAR: begin
              data_d  = '0;
              carry_d = 1'b0;
              done_d  = 1'b1;
            end
            CMD_INC: begin
              data_d  = data_q + ONE_W;
              carry_d = &data_q;
              done_d  = 1'b1;
            end
            CMD_DEC: begin
              data_d  = data_q - ONE_W;
              carry_d = ~|data_q;
              done_d  = 1'b1;
            end
            CMD_SHL, CMD_SHR, CMD_ROL: begin
              carry_d = 1'b0;
              if (in_AMT == '0) begin
                // zero-length shift completes immediately without going busy
                done_d = 1'b1;
              end else begin
                cmd_d   = cmd_in;
                cnt_d   = in_AMT;
                state_d = ST_SHIFT;
              end
            end
            default: begin
            end
          endcase
        end
      end

      ST_SHIFT: begin
        case (cmd_q)
          CMD_SHL: begin
            data_d = {data_q[WIDTH-2:0], in_SIN};
            sout_d = data_q[WIDTH-1];
          end
          CMD_SHR: begin
            data_d = {shr_fill, data_q[WIDTH-1:1]};
            sout_d = data_q[0];
          end
          CMD_ROL: begin
            data_d = {data_q[WIDTH-2:0], data_q[WIDTH-1]};
            sout_d = data_q[WIDTH-1];
          end
          default: begin
          end
        endcase
        cnt_d = cnt_q - ONE_AMT;
        if (cnt_q == ONE_AMT) begin
          // last shift: result and done pulse appear together next cycle
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any shift without a done pulse
  always_ff @(posedge in_CLK or negedge in_RST_N) begin
    if (!in_RST_N) begin
      state_q <= ST_IDLE;
      cmd_q   <= CMD_HOLD;
      data_q  <= RESET_VAL;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      sout_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      sout_q  <= sout_d;
      carry_q <= carry_d;
    end
  end

  assign data_out  = data_q;
  assign out_BUSY  = (state_q == ST_SHIFT);
  assign out_DONE  = done_q;
  assign out_SOUT  = sout_q;
  assign out_CARRY = carry_q;
  assign out_ZERO  = (data_q == '0);

endmodule

// File: tb/tb_shift_reg_en.sv
// tb/tb_shift_reg_en.sv - scoreboard testbench for shift_reg_en

module tb_shift_reg_en;

  logic       in_CLK = 1'b0;
  logic       in_RST_N = 1'b0;
  logic       in_EN = 1'b0;
  logic [2:0] in_CMD = 3'b000;
  logic [7:0] in_D = 8'h00;
  logic [2:0] in_AMT = 3'd0;
  logic       in_SIN = 1'b0;
  logic [7:0] data_out;
  logic       out_BUSY;
  logic       out_DONE;
  logic       out_SOUT;
  logic       out_CARRY;
  logic       out_ZERO;

  localparam logic [2:0] HOLD = 3'b000, LOAD = 3'b001, CLR = 3'b010, SHL = 3'b011,
                         SHR = 3'b100, ROL = 3'b101, INC = 3'b110, DEC = 3'b111;

  typedef struct packed {
    logic [7:0] d;
    logic       s;
    logic       c;
    logic       z;
  } exp_t;

  exp_t       done_exp[$];
  logic [7:0] busy_exp[$];

  int n_pass = 0;
  int n_total = 0;

  shift_reg_en #(.WIDTH(8), .AMT_W(3), .RESET_VAL(8'h00)) dut (
    .in_CLK   (in_CLK),
    .in_RST_N (in_RST_N),
    .in_EN    (in_EN),
    .in_CMD   (in_CMD),
    .in_D     (in_D),
    .in_AMT   (in_AMT),
    .in_SIN   (in_SIN),
    .data_out (data_out),
    .out_BUSY (out_BUSY),
    .out_DONE (out_DONE),
    .out_SOUT (out_SOUT),
    .out_CARRY(out_CARRY),
    .out_ZERO (out_ZERO)
  );

  always #5 in_CLK = ~in_CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
  endtask

  // Present one command for a single acceptance edge, then drop the strobe
  task automatic issue(input logic [2:0] cmd, input logic [7:0] d, input logic [2:0] amt,
                       input logic sin);
    in_EN  = 1'b1;
    in_CMD = cmd;
    in_D   = d;
    in_AMT = amt;
    in_SIN = sin;
    @(posedge in_CLK);
    #1;
    in_EN  = 1'b0;
  endtask

  task automatic exp_done(input logic [7:0] d, input logic s, input logic c);
    exp_t e;
    e.d = d;
    e.s = s;
    e.c = c;
    e.z = (d == 8'h00);
    done_exp.push_back(e);
  endtask

  // Monitor: compare against the scoreboard whenever the DUT reports busy or done
  always @(negedge in_CLK) begin
    if (out_BUSY) begin
      if (busy_exp.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_busy: got busy=1 data=0x%0h, expected busy=0 at %0t", data_out, $time);
      end else begin
        chk("busy_data", {24'h0, data_out}, {24'h0, busy_exp.pop_front()});
      end
    end
    if (out_DONE) begin
      if (done_exp.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_done: got done=1 data=0x%0h, expected done=0 at %0t", data_out, $time);
      end else begin
        chk("done_result {data,sout,carry,zero}",
            {21'h0, data_out, out_SOUT, out_CARRY, out_ZERO}, {21'h0, done_exp.pop_front()});
      end
    end
  end

  initial begin
    // reset held for two cycles
    repeat (2) @(negedge in_CLK);
    chk("rst_data", {24'h0, data_out}, 32'h00);
    chk("rst_busy", {31'h0, out_BUSY}, 32'h0);
    chk("rst_done", {31'h0, out_DONE}, 32'h0);
    chk("rst_carry", {31'h0, out_CARRY}, 32'h0);
    chk("rst_zero", {31'h0, out_ZERO}, 32'h1);
    in_RST_N = 1'b1;
    @(posedge in_CLK);
    #1;

    // load and 3-bit left shift with serial fill 1
    exp_done(8'hA5, 1'b0, 1'b0);
    issue(LOAD, 8'hA5, 3'd0, 1'b0);
    busy_exp.push_back(8'hA5);
    busy_exp.push_back(8'h4B);
    busy_exp.push_back(8'h97);
    exp_done(8'h2F, 1'b1, 1'b0);
    issue(SHL, 8'h00, 3'd3, 1'b1);
    repeat (3) begin @(posedge in_CLK); #1; end

    // rotate 0x81 left by one
    exp_done(8'h81, 1'b1, 1'b0);
    issue(LOAD, 8'h81, 3'd0, 1'b0);
    busy_exp.push_back(8'h81);
    exp_done(8'h03, 1'b1, 1'b0);
    issue(ROL, 8'h00, 3'd1, 1'b0);
    @(posedge in_CLK); #1;

    // increment/decrement wraparound and carry clearing
    exp_done(8'hFF, 1'b1, 1'b0); issue(LOAD, 8'hFF, 3'd0, 1'b0);
    exp_done(8'h00, 1'b1, 1'b1); issue(INC, 8'h00, 3'd0, 1'b0);
    exp_done(8'hFF, 1'b1, 1'b1); issue(DEC, 8'h00, 3'd0, 1'b0);
    exp_done(8'hFE, 1'b1, 1'b0); issue(DEC, 8'h00, 3'd0, 1'b0);
    exp_done(8'h00, 1'b1, 1'b0); issue(LOAD, 8'h00, 3'd0, 1'b0);
    exp_done(8'hFF, 1'b1, 1'b1); issue(DEC, 8'h00, 3'd0, 1'b0);
    exp_done(8'hFF, 1'b1, 1'b0); issue(SHL, 8'h00, 3'd0, 1'b0);
    exp_done(8'h00, 1'b1, 1'b0); issue(LOAD, 8'h00, 3'd0, 1'b0);
    exp_done(8'hFF, 1'b1, 1'b1); issue(DEC, 8'h00, 3'd0, 1'b0);
    exp_done(8'h00, 1'b1, 1'b0); issue(CLR, 8'h00, 3'd0, 1'b0);
    issue(HOLD, 8'h77, 3'd2, 1'b0);
    @(posedge in_CLK); #1;
    chk("hold_data", {24'h0, data_out}, 32'h00);

    // right shift by 4 with a LOAD attempted while busy
    exp_done(8'hF0, 1'b1, 1'b0);
    issue(LOAD, 8'hF0, 3'd0, 1'b0);
    busy_exp.push_back(8'hF0);
`ifdef SHIFT_REG_ARITH_SHR_EN
    busy_exp.push_back(8'hF8);
    busy_exp.push_back(8'hFC);
    busy_exp.push_back(8'hFE);
    exp_done(8'hFF, 1'b0, 1'b0);
`else
    busy_exp.push_back(8'h78);
    busy_exp.push_back(8'h3C);
    busy_exp.push_back(8'h1E);
    exp_done(8'h0F, 1'b0, 1'b0);
`endif
    issue(SHR, 8'h00, 3'd4, 1'b0);
    @(posedge in_CLK); #1;
    issue(LOAD, 8'h11, 3'd0, 1'b0);
    repeat (2) begin @(posedge in_CLK); #1; end

    // reset asserted in the second cycle of a 5-bit shift
    exp_done(8'h96, 1'b0, 1'b0);
    issue(LOAD, 8'h96, 3'd0, 1'b0);
    busy_exp.push_back(8'h96);
    busy_exp.push_back(8'h2C);
    issue(SHL, 8'h00, 3'd5, 1'b0);
    @(posedge in_CLK); #1;
    @(negedge in_CLK); #2;
    in_RST_N = 1'b0;
    #1;
    chk("midrst_data", {24'h0, data_out}, 32'h00);
    chk("midrst_busy", {31'h0, out_BUSY}, 32'h0);
    chk("midrst_done", {31'h0, out_DONE}, 32'h0);
    @(negedge in_CLK); #1;
    in_RST_N = 1'b1;
    repeat (3) begin @(posedge in_CLK); #1; end
    chk("midrst_busy_drained", busy_exp.size(), 32'd0);
    exp_done(8'h3C, 1'b0, 1'b0);
    issue(LOAD, 8'h3C, 3'd0, 1'b0);

    repeat (3) begin @(posedge in_CLK); #1; end
    chk("done_queue_empty", done_exp.size(), 32'd0);
    chk("busy_queue_empty", busy_exp.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
